// File: rtl/cve2_multdiv_arbiter.sv
/******************************************************************************
 * Module : cve2_multdiv_arbiter (with minimal cve2_pkg type definitions)
 * Brief  : Two-port arbiter sharing the EX-block multiply/divide path.
 *          Macro CVE2_MD_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
 *          undefined gives fixed priority to port 0.
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

package cve2_pkg;
  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module cve2_multdiv_arbiter #(
  parameter cve2_pkg::rv32m_e RV32M = cve2_pkg::RV32MFast
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_op_i     [2],
  input  logic [1:0]  req_signed_i [2],
  input  logic [31:0] req_a_i      [2],
  input  logic [31:0] req_b_i      [2],

  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_data_o,
  input  logic [1:0]  abort_i,

  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        multdiv_ready_id_o,
  input  logic        ex_valid_i,
  input  logic [31:0] result_i
);

  localparam logic c_md_en = (RV32M != cve2_pkg::RV32MNone);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        owner_q;
  logic        kill_q;
  logic [1:0]  op_q;
  logic [1:0]  signed_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;

  logic        w_prio;
  logic [1:0]  w_grant;
  logic        w_grant_idx;
  logic        w_busy;
  logic        w_resp;
  logic        w_done;
  logic        w_owner_abort;

  // w_prio names the port that wins when both request in the same cycle
  always_comb begin
    w_grant = 2'b00;
    if (state_q == IDLE) begin
      if (req_valid_i == 2'b11) begin
        w_grant = w_prio ? 2'b10 : 2'b01;
      end else begin
        w_grant = req_valid_i;
      end
    end
  end

  assign w_grant_idx = w_grant[1];
  assign req_ready_o = w_grant;

`ifdef CVE2_MD_ARB_ROUND_ROBIN_EN
  logic prio_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (|w_grant) begin
      prio_q <= ~w_grant_idx;
    end
  end

  assign w_prio = prio_q;
`else
  assign w_prio = 1'b0;
`endif

  assign w_busy        = (state_q == BUSY);
  assign w_resp        = (state_q == RESP);
  assign w_owner_abort = abort_i[owner_q];
  // Without a multdiv unit nothing will raise ex_valid, so complete at once
  assign w_done        = c_md_en ? ex_valid_i : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      kill_q   <= 1'b0;
      op_q     <= 2'b00;
      signed_q <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|w_grant) begin
            owner_q  <= w_grant_idx;
            op_q     <= req_op_i[w_grant_idx];
            signed_q <= req_signed_i[w_grant_idx];
            a_q      <= req_a_i[w_grant_idx];
            b_q      <= req_b_i[w_grant_idx];
            kill_q   <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // An abort never truncates the EX operation; it only drops the result
          if (w_done) begin
            kill_q <= 1'b0;
            if (kill_q || w_owner_abort) begin
              state_q <= IDLE;
            end else begin
              result_q <= c_md_en ? result_i : 32'd0;
              state_q  <= RESP;
            end
          end else if (w_owner_abort) begin
            kill_q <= 1'b1;
          end
        end
        RESP: begin
          if (w_owner_abort || rsp_ready_i[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mult_sel_o         = w_busy & c_md_en & ~op_q[1];
  assign mult_en_o          = w_busy & c_md_en & ~op_q[1];
  assign div_sel_o          = w_busy & c_md_en &  op_q[1];
  assign div_en_o           = w_busy & c_md_en &  op_q[1];
  assign operator_o         = w_busy ? op_q     : 2'b00;
  assign signed_mode_o      = w_busy ? signed_q : 2'b00;
  assign op_a_o             = w_busy ? a_q      : 32'd0;
  assign op_b_o             = w_busy ? b_q      : 32'd0;
  assign multdiv_ready_id_o = w_busy & c_md_en & ex_valid_i;

  assign rsp_valid_o = w_resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data_o  = w_resp ? result_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_cve2_multdiv_arbiter.sv
/******************************************************************************
 * Module : tb_cve2_multdiv_arbiter
 * Brief  : Directed scoreboard bench for cve2_multdiv_arbiter; honours
 *          CVE2_MD_ARB_ROUND_ROBIN_EN when choosing arbitration expectations.
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

module tb_cve2_multdiv_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_op_i     [2];
  logic [1:0]  req_signed_i [2];
  logic [31:0] req_a_i      [2];
  logic [31:0] req_b_i      [2];
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  abort_i;
  logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]  operator_o, signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic        multdiv_ready_id_o;
  logic        ex_valid_i;
  logic [31:0] result_i;

`ifdef CVE2_MD_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  cve2_multdiv_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_signed_i       (req_signed_i),
    .req_a_i            (req_a_i),
    .req_b_i            (req_b_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_data_o         (rsp_data_o),
    .abort_i            (abort_i),
    .mult_en_o          (mult_en_o),
    .div_en_o           (div_en_o),
    .mult_sel_o         (mult_sel_o),
    .div_sel_o          (div_sel_o),
    .operator_o         (operator_o),
    .signed_mode_o      (signed_mode_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .multdiv_ready_id_o (multdiv_ready_id_o),
    .ex_valid_i         (ex_valid_i),
    .result_i           (result_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   men_cnt = 0;
  int   rdy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on port p in an IDLE cycle; returns at #1 of the first BUSY cycle
  task automatic issue(input int p, input logic [1:0] op, input logic [1:0] sg,
                       input logic [31:0] a, input logic [31:0] b);
    req_op_i[p]     = op;
    req_signed_i[p] = sg;
    req_a_i[p]      = a;
    req_b_i[p]      = b;
    req_valid_i[p]  = 1'b1;
    @(negedge clk);
    chk("grant", {30'd0, req_ready_o}, (p == 1) ? 32'd2 : 32'd1);
    tick();
    req_valid_i[p] = 1'b0;
  endtask

  task automatic ex_finish(input int delay, input logic [31:0] res);
    repeat (delay) tick();
    ex_valid_i = 1'b1;
    result_i   = res;
    tick();
    ex_valid_i = 1'b0;
    result_i   = 32'd0;
  endtask

  // Monitor: every response handshake must match the oldest expected response
  always @(negedge clk) begin
    if (!rst_i && ((rsp_valid_o & rsp_ready_i) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got valid %b data %h, expected none", rsp_valid_o, rsp_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_port", {31'd0, rsp_valid_o[1]}, {31'd0, e.port});
        chk("rsp_data", rsp_data_o, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (mult_en_o) men_cnt++;
    if (multdiv_ready_id_o) rdy_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          men0, rdy0;
    logic [1:0]  exp_g;

    rst_i       = 1'b1;
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    abort_i     = 2'b00;
    ex_valid_i  = 1'b0;
    result_i    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      req_op_i[i] = 2'd0; req_signed_i[i] = 2'd0; req_a_i[i] = 32'd0; req_b_i[i] = 32'd0;
    end
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready_o}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("rst_mult_en",   {31'd0, mult_en_o}, 32'd0);
    chk("rst_op_a",      op_a_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Port 0 MULL 7*6, EX valid two cycles after BUSY starts
    men0 = men_cnt; rdy0 = rdy_cnt;
    exp_q.push_back('{port: 1'b0, data: 32'd42});
    issue(0, 2'd0, 2'b00, 32'd7, 32'd6);
    @(negedge clk);
    chk("t1_mult_en",  {31'd0, mult_en_o},  32'd1);
    chk("t1_mult_sel", {31'd0, mult_sel_o}, 32'd1);
    chk("t1_div_en",   {31'd0, div_en_o},   32'd0);
    chk("t1_op_a",     op_a_o, 32'd7);
    chk("t1_op_b",     op_b_o, 32'd6);
    ex_finish(2, 32'd42);
    @(negedge clk);
    chk("t1_rsp_valid", {30'd0, rsp_valid_o}, 32'd1);
    chk("t1_mult_en_resp", {31'd0, mult_en_o}, 32'd0);
    chk("t1_mult_en_cycles", men_cnt - men0, 32'd3);
    chk("t1_ready_pulses",   rdy_cnt - rdy0, 32'd1);
    tick();

    // Port 1 signed DIV -20/3; a non-owner abort on port 0 must be ignored
    exp_q.push_back('{port: 1'b1, data: 32'hFFFF_FFFA});
    issue(1, 2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3);
    abort_i = 2'b01;
    @(negedge clk);
    chk("t2_div_sel",  {31'd0, div_sel_o},  32'd1);
    chk("t2_div_en",   {31'd0, div_en_o},   32'd1);
    chk("t2_mult_en",  {31'd0, mult_en_o},  32'd0);
    chk("t2_signed",   {30'd0, signed_mode_o}, 32'd3);
    chk("t2_operator", {30'd0, operator_o}, 32'd2);
    tick();
    abort_i = 2'b00;
    ex_finish(0, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("t2_rsp_valid", {30'd0, rsp_valid_o}, 32'd2);
    tick();

    // Both ports request continuously, MULL 1*1
    for (int i = 0; i < 2; i++) begin
      req_op_i[i] = 2'd0; req_signed_i[i] = 2'd0; req_a_i[i] = 32'd1; req_b_i[i] = 32'd1;
    end
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
      @(negedge clk);
      chk("t3_grant", {30'd0, req_ready_o}, {30'd0, exp_g});
      exp_q.push_back('{port: exp_g[1], data: 32'd1});
      tick();
      @(negedge clk);
      chk("t3_busy_ready", {30'd0, req_ready_o}, 32'd0);
      ex_valid_i = 1'b1;
      result_i   = 32'd1;
      tick();
      ex_valid_i = 1'b0;
      result_i   = 32'd0;
      tick();
    end
    req_valid_i = 2'b00;

    // Owner abort one cycle into BUSY, EX completes five cycles after the abort
    issue(0, 2'd2, 2'b00, 32'd100, 32'd7);
    @(negedge clk);
    chk("t4_div_en", {31'd0, div_en_o}, 32'd1);
    tick();
    abort_i = 2'b01;
    tick();
    abort_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_no_rsp", {30'd0, rsp_valid_o}, 32'd0);
      tick();
    end
    ex_valid_i = 1'b1;
    result_i   = 32'd14;
    @(negedge clk);
    chk("t4_md_ready", {31'd0, multdiv_ready_id_o}, 32'd1);
    tick();
    ex_valid_i = 1'b0;
    result_i   = 32'd0;
    exp_q.push_back('{port: 1'b1, data: 32'd5});
    issue(1, 2'd0, 2'b00, 32'd5, 32'd1);
    ex_finish(0, 32'd5);
    @(negedge clk);
    chk("t4_next_rsp", {30'd0, rsp_valid_o}, 32'd2);
    tick();

    // Response back-pressure with both requesters pending
    rsp_ready_i = 2'b00;
    exp_q.push_back('{port: 1'b0, data: 32'd1});
    issue(0, 2'd1, 2'b00, 32'h0001_0000, 32'h0001_0000);
    req_valid_i = 2'b11;
    ex_finish(0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_rsp_valid", {30'd0, rsp_valid_o}, 32'd1);
      chk("t5_rsp_data",  rsp_data_o, 32'd1);
      chk("t5_req_ready", {30'd0, req_ready_o}, 32'd0);
      tick();
    end
    rsp_ready_i = 2'b01;
    @(negedge clk);
    chk("t5_rsp_hold", {30'd0, rsp_valid_o}, 32'd1);
    tick();
    rsp_ready_i = 2'b11;
    @(negedge clk);
    chk("t5_regrant", {30'd0, req_ready_o}, RR ? 32'd2 : 32'd1);
    tick();
    req_valid_i = 2'b00;

    // Reset asserted mid-BUSY with EX completing in the same cycle
    @(negedge clk);
    chk("t6_busy", {31'd0, mult_en_o}, 32'd1);
    tick();
    rst_i      = 1'b1;
    ex_valid_i = 1'b1;
    result_i   = 32'hDEAD_BEEF;
    tick();
    ex_valid_i = 1'b0;
    result_i   = 32'd0;
    @(negedge clk);
    chk("t6_mult_en",  {31'd0, mult_en_o},  32'd0);
    chk("t6_mult_sel", {31'd0, mult_sel_o}, 32'd0);
    chk("t6_div_en",   {31'd0, div_en_o},   32'd0);
    chk("t6_div_sel",  {31'd0, div_sel_o},  32'd0);
    chk("t6_operator", {30'd0, operator_o}, 32'd0);
    chk("t6_op_a",     op_a_o, 32'd0);
    chk("t6_op_b",     op_b_o, 32'd0);
    chk("t6_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("t6_rsp_data", rsp_data_o, 32'd0);
    chk("t6_md_ready", {31'd0, multdiv_ready_id_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_rsp", {30'd0, rsp_valid_o}, 32'd0);
      tick();
    end

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cve2_multdiv_arbiter.md
# cve2_multdiv_arbiter

Shares one `cve2_ex_block` multiplier/divider path between two requesters: port 0 is the core ID stage and port 1 is an auxiliary unit such as a debug or accelerator sequencer. The block accepts one request at a time and latches its operands. It then drives the static select and dynamic enable controls into the EX block, waits for `ex_valid`, captures the result and returns it to the owning requester. It sits between the requesters and the EX block's multdiv inputs and owns the multdiv operand/control mux.

## Interface
Parameters:
- `RV32M`, default `cve2_pkg::RV32MFast`: must match the EX block. With `RV32MNone`, requests are still granted and every response carries data 0.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high
- `req_valid_i`  in  2  per-port request valid
- `req_ready_o`  out  2  per-port grant; request accepted when valid && ready
- `req_op_i[2]`  in  2 each  `md_op_e` (MULL=0, MULH=1, DIV=2, REM=3)
- `req_signed_i[2]`  in  2 each  signed mode
- `req_a_i[2]`, `req_b_i[2]`  in  32 each  operands
- `rsp_valid_o`  out  2  per-port response valid
- `rsp_ready_i`  in  2  per-port response accept
- `rsp_data_o`  out  32  result, shared by both ports
- `abort_i`  in  2  per-port abort
- `mult_en_o`, `div_en_o`, `mult_sel_o`, `div_sel_o`  out  1  EX controls
- `operator_o`  out  2  EX operator; `signed_mode_o`  out  2  EX signed mode
- `op_a_o`, `op_b_o`  out  32  EX operands
- `multdiv_ready_id_o`  out  1  result-consumed strobe to EX
- `ex_valid_i`  in  1  EX valid
- `result_i`  in  32  EX result

## Operation
- FSM states:
  - IDLE: `req_ready_o` may be nonzero.
  - BUSY: operation in flight.
  - RESP: result held for the owner.
- IDLE, no request valid: stay in IDLE.
- IDLE, one or both requests valid:
  - Grant exactly one port. `req_ready_o` is one-hot and combinational from `req_valid_i` and the priority state.
  - Latch the op, signed mode, operands and owner id.
  - Go to BUSY.
- BUSY:
  - `mult_sel_o`/`mult_en_o` = 1 for MULL/MULH; `div_sel_o`/`div_en_o` = 1 for DIV/REM.
  - Operands and operator come from the latched registers.
  - When `ex_valid_i` = 1: capture `result_i`, pulse `multdiv_ready_id_o` in that same cycle, then go to RESP.
- RESP:
  - All EX enables and selects are 0.
  - `rsp_valid_o[owner]` = 1 and `rsp_data_o` = captured result, both held until `rsp_ready_i[owner]`.
  - On `rsp_ready_i[owner]`, go to IDLE.
- Abort by the owner:
  - In BUSY: set a kill flag. The EX operation runs to completion and is not truncated, because the iterative unit's FSM must end cleanly. At completion the result is discarded, no response is given, and the FSM goes directly to IDLE.
  - In RESP: drop the response and go to IDLE.
  - `abort_i` of a non-owner port is ignored.
- Outside BUSY, `op_a_o`/`op_b_o`/`operator_o`/`signed_mode_o` are 0.
- Reset values:
  - State = IDLE.
  - Priority pointer = port 0.
  - Kill flag = 0.
  - All latched registers = 0.
  - All outputs = 0 (`req_ready_o` settles once valids are sampled).

## Timing
- Request accepted in cycle N. BUSY begins in N+1, with enables high in N+1.
- With `ex_valid_i` high in cycle M ≥ N+1, `rsp_valid_o` rises in M+1.
- Minimum latency from accept to response is 2 cycles.
- Back-to-back: the response accepted in cycle R lets a new grant occur in R+1.
- Throughput is at most one operation per 3 cycles.
- `req_ready_o` is 0 in BUSY and RESP. A requester that holds valid keeps its request pending.
- Reset in any state (including BUSY) returns the block to IDLE in the next cycle and discards any result. The EX unit is reset by the same reset.

## Configuration
- Macro `CVE2_MD_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration. On simultaneous requests, the port not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, port 0 always wins. The pointer register is removed.

## Test plan
- Port 0 MULL, a=7, b=6, EX valid 2 cycles after start → `rsp_valid_o` = 2'b01 with `rsp_data_o` = 42, exactly 1 `multdiv_ready_id_o` pulse, and `mult_en_o` high for exactly those cycles.
- Port 1 DIV signed, a=-20, b=3 → `div_sel_o` = 1, `signed_mode_o` = 2'b11, response on port 1 with `rsp_data_o` = 0xFFFFFFFA (-6).
- Both ports request continuously with MULL 1×1:
  - round-robin: grants alternate 0,1,0,1;
  - fixed priority: port 0 always wins and port 1 is never granted.
- Port 0 DIV, owner abort 1 cycle into BUSY, EX valid 5 cycles later → no `rsp_valid_o`, FSM is IDLE the cycle after `ex_valid_i`, and the next request is granted.
- Response back-pressure: `rsp_ready_i` held 0 for 4 cycles → `rsp_valid_o` and `rsp_data_o` stay stable, and `req_ready_o` stays 0 throughout.
- `rst_i` asserted mid-BUSY → all outputs 0 on the following cycle, and no response is issued for the interrupted operation.
